// File: rtl/filter_stream_reader.sv
// Filter buffer read side: captures a parallel filter image and streams its
// coefficients over valid/ready, replaying the filter for a programmable number of passes.
module filter_stream_reader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DATA_W*DEPTH-1:0] filterIn,
  input  logic                    load,
  input  logic [4:0]              filterLen,
  input  logic [7:0]              repeatCnt,
  input  logic                    start,
  output logic                    busy,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [DATA_W-1:0]       dataOut,
  output logic [3:0]              outIdx,
  output logic                    outLast,
  output logic                    done
);

  // state  | meaning
  // IDLE   | waiting for start; store may be loaded
  // STREAM | presenting store[idx], advancing on each transfer
  // DONE   | single-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] store [DEPTH];
  logic [DATA_W-1:0] img_coef [DEPTH];
  logic [3:0]        idx, idx_nxt;
  logic [7:0]        pass, pass_nxt;
  logic [4:0]        len, len_nxt;
  logic [7:0]        passes, passes_nxt;
  logic              load_ok, xfer, last_now, stream_nxt;

  assign load_ok  = load && !busy;
  assign xfer     = outValid && outReady;
  assign last_now = ({1'b0, idx} == len - 5'd1);

  // Newly loaded data is visible to a run started at the same edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      img_coef[i] = load_ok ? filterIn[DATA_W*(DEPTH-1-i) +: DATA_W] : store[i];
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    pass_nxt   = pass;
    len_nxt    = len;
    passes_nxt = passes;
    unique case (state)
      S_IDLE: begin
        if (start && filterLen != 5'd0) begin
          state_nxt  = S_STREAM;
          len_nxt    = (filterLen > 5'(DEPTH)) ? 5'(DEPTH) : filterLen;
          passes_nxt = (repeatCnt == 8'd0) ? 8'd1 : repeatCnt;
          idx_nxt    = '0;
          pass_nxt   = '0;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (last_now) begin
            idx_nxt = '0;
            if (pass == passes - 8'd1) state_nxt = S_DONE;
            else                       pass_nxt  = pass + 8'd1;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stream_nxt = (state_nxt == S_STREAM);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      idx      <= '0;
      pass     <= '0;
      len      <= '0;
      passes   <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      busy     <= 1'b0;
      outValid <= 1'b0;
      dataOut  <= '0;
      outIdx   <= '0;
      outLast  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      pass   <= pass_nxt;
      len    <= len_nxt;
      passes <= passes_nxt;
      if (load_ok) begin
        for (int i = 0; i < DEPTH; i++) store[i] <= img_coef[i];
      end
      // Outputs are registered from next-state values so nothing is combinational from inputs.
      busy     <= (state_nxt != S_IDLE);
      outValid <= stream_nxt;
      dataOut  <= stream_nxt ? img_coef[idx_nxt] : '0;
      outIdx   <= stream_nxt ? idx_nxt : '0;
      outLast  <= stream_nxt && ({1'b0, idx_nxt} == len_nxt - 5'd1);
      done     <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_filter_stream_reader.sv
// Scoreboard bench for filter_stream_reader: the driver pushes expected coefficients per run,
// a negedge monitor compares every presented coefficient and every done pulse.
module tb_filter_stream_reader;

  logic         clk = 1'b0;
  logic         rstn;
  logic [127:0] filterIn;
  logic         load, start, outReady;
  logic [4:0]   filterLen;
  logic [7:0]   repeatCnt;
  logic         busy, outValid, outLast, done;
  logic [7:0]   dataOut;
  logic [3:0]   outIdx;

  filter_stream_reader #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .filterIn(filterIn), .load(load), .filterLen(filterLen),
    .repeatCnt(repeatCnt), .start(start), .busy(busy), .outValid(outValid),
    .outReady(outReady), .dataOut(dataOut), .outIdx(outIdx), .outLast(outLast), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] i;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  int         done_exp = 0;
  logic [7:0] mstore [16];
  int         n_cmp = 0, n_err = 0;
  int         n_last = 0, n_done = 0;
  int         rdy_mode = 0;
  int         rdy_phase = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [127:0] rand_img();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // 0: always ready, 1: pattern 1,0,0 repeating, 2: random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       outReady = 1'b1;
      1:       begin outReady = (rdy_phase == 0); rdy_phase = (rdy_phase + 1) % 3; end
      default: outReady = 1'($urandom_range(0, 1));
    endcase
  end

  exp_t e;
  always @(negedge clk) begin
    if (rstn) begin
      if (outValid) begin
        if (exp_q.size() == 0) begin
          chk("extra_valid_count", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q[0];
          chk("dataOut", 32'(dataOut), 32'(e.d));
          chk("outIdx", 32'(outIdx), 32'(e.i));
          chk("outLast", 32'(outLast), 32'(e.l));
          if (outReady) begin
            void'(exp_q.pop_front());
            if (outLast) n_last++;
          end
        end
      end
      if (done) begin
        n_done++;
        chk("done_after_final_xfer", 32'(exp_q.size()), 32'd0);
        chk("done_expected", 32'(done_exp > 0), 32'd1);
        if (done_exp > 0) done_exp--;
      end
    end
  end

  // Called just after a rising edge with the DUT idle; returns just after the accepting edge.
  task automatic do_run(input logic [127:0] img, input bit ld, input int len, input int rep);
    int eff, np;
    filterIn  = img;
    load      = ld;
    filterLen = 5'(len);
    repeatCnt = 8'(rep);
    start     = 1'b1;
    if (ld) for (int i = 0; i < 16; i++) mstore[i] = img[8*(15-i) +: 8];
    if (len != 0) begin
      eff = (len > 16) ? 16 : len;
      np  = (rep == 0) ? 1 : rep;
      for (int p = 0; p < np; p++)
        for (int i = 0; i < eff; i++)
          exp_q.push_back('{d: mstore[i], i: 4'(i), l: (i == eff - 1)});
      done_exp++;
    end
    @(posedge clk); #1;
    load  = 1'b0;
    start = 1'b0;
  endtask

  // Load/start noise while busy must be ignored by the DUT, so the model ignores it too.
  task automatic wait_idle(input bit noise);
    for (int c = 0; c < 1000; c++) begin
      if (!busy) begin
        load  = 1'b0;
        start = 1'b0;
        return;
      end
      if (noise) begin
        load      = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
        filterIn  = rand_img();
        filterLen = 5'($urandom_range(0, 20));
        repeatCnt = 8'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
    end
    load  = 1'b0;
    start = 1'b0;
    chk("idle_timeout_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_outValid"}, 32'(outValid), 0);
    chk({tag, "_dataOut"}, 32'(dataOut), 0);
    chk({tag, "_outIdx"}, 32'(outIdx), 0);
    chk({tag, "_outLast"}, 32'(outLast), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  logic [127:0] ramp;
  int           last0, done0;

  initial begin
    rstn = 1'b0; load = 1'b0; start = 1'b0; outReady = 1'b1;
    filterIn = '0; filterLen = '0; repeatCnt = '0;
    for (int i = 0; i < 16; i++) mstore[i] = 8'h00;
    for (int i = 0; i < 16; i++) ramp[8*(15-i) +: 8] = 8'(i);
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(posedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;

    // full filter, single pass, exact timing
    rdy_mode = 0;
    do_run(ramp, 1, 16, 1);
    chk("t1_busy_T1", 32'(busy), 1);
    chk("t1_valid_T1", 32'(outValid), 1);
    repeat (16) @(posedge clk);
    #1 chk("t1_done_T17", 32'(done), 1);
    chk("t1_busy_T17", 32'(busy), 1);
    @(posedge clk); #1;
    chk("t1_busy_T18", 32'(busy), 0);
    chk("t1_done_T18", 32'(done), 0);

    // three passes of nine
    last0 = n_last; done0 = n_done;
    do_run(ramp, 0, 9, 3);
    wait_idle(0);
    repeat (2) @(posedge clk); #1;
    chk("t2_last_count", 32'(n_last - last0), 3);
    chk("t2_done_count", 32'(n_done - done0), 1);

    // stalls
    rdy_mode = 1; rdy_phase = 0;
    do_run(ramp, 0, 4, 1);
    wait_idle(0);

    // load and start while streaming are ignored
    rdy_mode = 2;
    do_run(ramp, 0, 8, 2);
    @(posedge clk); #1;
    load = 1'b1; filterIn = rand_img(); start = 1'b1; filterLen = 5'd3; repeatCnt = 8'd1;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    wait_idle(0);
    do_run(rand_img(), 0, 16, 1);
    wait_idle(0);

    // length / repeat boundaries
    rdy_mode = 0;
    do_run(ramp, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      chk("len0_valid", 32'(outValid), 0);
      chk("len0_busy", 32'(busy), 0);
      @(posedge clk); #1;
    end
    do_run(ramp, 0, 20, 1);
    wait_idle(0);
    do_run(ramp, 0, 5, 0);
    wait_idle(0);

    // reset mid-run
    do_run(ramp, 0, 16, 1);
    repeat (5) @(posedge clk);
    #1 chk("rst_idx_before", 32'(outIdx), 5);
    #1 rstn = 1'b0;
    exp_q.delete();
    done_exp = 0;
    for (int i = 0; i < 16; i++) mstore[i] = 8'h00;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1 chk("midrst_done_held", 32'(done), 0);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    do_run(ramp, 0, 16, 1);
    wait_idle(0);

    // randomized runs with noise and random back-pressure
    rdy_mode = 2;
    for (int r = 0; r < 25; r++) begin
      do_run(rand_img(), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 20), $urandom_range(0, 3));
      wait_idle(1);
    end

    repeat (3) @(posedge clk); #1;
    chk("end_queue_empty", 32'(exp_q.size()), 0);
    chk("end_done_pending", 32'(done_exp), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
